// File: rtl/and_unit_rr_sched.sv
// Round-robin scheduler sharing one WIDTH-bit AND stage among NREQ requesters.
// One grant per cycle; registered result returned with the requester index.
module and_unit_rr_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           done_cnt
);

    logic [NREQ-1:0][WIDTH-1:0] and_res;
    logic [ID_W-1:0]            ptr_reg;
    logic                       rsp_valid_reg;
    logic [WIDTH-1:0]           rsp_data_reg;
    logic [ID_W-1:0]            rsp_id_reg;
    logic [15:0]                done_cnt_reg;

    logic                       slot_free;
    logic                       found;
    logic [ID_W-1:0]            gnt_idx;
    logic [ID_W-1:0]            cand_idx;
    logic [NREQ-1:0]            gnt_vec;
    int                         cand;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_and
            assign and_res[gi] = op_a[gi*WIDTH +: WIDTH] & op_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign slot_free = !rsp_valid_reg || rsp_ready;

    // Search starts one past the last winner, so ptr=NREQ-1 begins at index 0.
    always_comb begin
        gnt_vec  = '0;
        gnt_idx  = '0;
        cand_idx = '0;
        found    = 1'b0;
        cand     = 0;
        if (!rst && slot_free) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = int'(ptr_reg) + k;
                if (cand >= NREQ) cand = cand - NREQ;
                cand_idx = ID_W'(cand);
                if (!found && req[cand_idx]) begin
                    found            = 1'b1;
                    gnt_idx          = cand_idx;
                    gnt_vec[cand_idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= ID_W'(NREQ - 1);
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
            done_cnt_reg  <= '0;
        end else begin
            if (rsp_valid_reg && rsp_ready) done_cnt_reg <= done_cnt_reg + 16'd1;
            if (slot_free) rsp_valid_reg <= found;
            // Data and id hold across a bubble; only a new grant overwrites them.
            if (found) begin
                rsp_data_reg <= and_res[gnt_idx];
                rsp_id_reg   <= gnt_idx;
                ptr_reg      <= gnt_idx;
            end
        end
    end

    assign gnt       = gnt_vec;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign done_cnt  = done_cnt_reg;

endmodule

// File: tb/tb_and_unit_rr_sched.sv
// Directed bench for and_unit_rr_sched: vector table plus reset and counter-wrap sequences.
module tb_and_unit_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] done_cnt;

    int checks = 0;
    int errors = 0;

    and_unit_rr_sched #(.NREQ(4), .WIDTH(8), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic [3:0]  gnt;
        logic        vld;
        logic [7:0]  data;
        logic [1:0]  id;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = '0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        // Operand results: r0 FF&11=11, r1 AA&0F=0A, r2 F0&3C=30, r3 5A&FF=5A
        op_a = {8'h5A, 8'hF0, 8'hAA, 8'hFF};
        op_b = {8'hFF, 8'h3C, 8'h0F, 8'h11};
        rst = 1'b1; req = '0; rsp_ready = 1'b1;

        //                req      rdy   gnt      vld   data   id    cnt
        vecs[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h30, 2'd2, 16'd0};
        vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h30, 2'd2, 16'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h5A, 2'd3, 16'd1};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd2};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h0A, 2'd1, 16'd3};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h30, 2'd2, 16'd4};
        vecs[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h5A, 2'd3, 16'd5};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd6};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 16'd6};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 16'd6};
        vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 16'd6};
        vecs[11] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h0A, 2'd1, 16'd7};
        vecs[12] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'h5A, 2'd3, 16'd8};
        vecs[13] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd9};
        vecs[14] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 8'h5A, 2'd3, 16'd10};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h5A, 2'd3, 16'd10};
        vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd3, 16'd11};
        vecs[17] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 8'h0A, 2'd1, 16'd11};
        vecs[18] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 8'h0A, 2'd1, 16'd11};
        vecs[19] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd12};

        // Reset state
        #2;
        chk("gnt_in_reset", 32'(gnt), 32'h0);
        do_reset();
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_data", 32'(rsp_data), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_cnt", 32'(done_cnt), 32'h0);

        for (int i = 0; i < 20; i++) begin
            req = vecs[i].req; rsp_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'(vecs[i].vld));
            chk($sformatf("v%0d_data", i), 32'(rsp_data), 32'(vecs[i].data));
            chk($sformatf("v%0d_id", i), 32'(rsp_id), 32'(vecs[i].id));
            chk($sformatf("v%0d_cnt", i), 32'(done_cnt), 32'(vecs[i].cnt));
            $display("vec %0d req=%b rdy=%b gnt=%b vld=%b data=%h id=%0d cnt=%0d",
                     i, vecs[i].req, vecs[i].rdy, gnt, rsp_valid, rsp_data, rsp_id, done_cnt);
        end

        // Asynchronous reset with a pending response and done_cnt=5
        do_reset();
        req = 4'b1111; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
        chk("pre_rst_cnt", 32'(done_cnt), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(rsp_valid), 32'h0);
        chk("async_data", 32'(rsp_data), 32'h0);
        chk("async_cnt", 32'(done_cnt), 32'h0);
        chk("async_gnt", 32'(gnt), 32'h0);
        $display("async reset: vld=%b data=%h cnt=%0d", rsp_valid, rsp_data, done_cnt);
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b1010;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'b0010);
        @(posedge clk); #1;
        chk("post_rst_id", 32'(rsp_id), 32'd1);
        chk("post_rst_data", 32'(rsp_data), 32'h0A);

        // Counter wrap: 65535 transfers then one more
        do_reset();
        req = 4'b1111; rsp_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        chk("cnt_ffff", 32'(done_cnt), 32'hFFFF);
        @(posedge clk); #1;
        chk("cnt_wrap", 32'(done_cnt), 32'h0);
        $display("counter wrap: cnt=%0h", done_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
